// File: rtl/dc_mem_bridge_pkg.sv
// Shared data-cache / memory-bridge configuration: FSM encoding, line geometry and address field positions.
package dc_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    WR_MEM = 2'd2
  } bridge_state_t;

  localparam int DC_WORD_W     = 32;
  localparam int DC_LINE_WORDS = 8;
  localparam int DC_WORD_LSB   = 2;
  localparam int DC_IDX_W      = $clog2(DC_LINE_WORDS);
  localparam int DC_LINE_LSB   = DC_WORD_LSB + DC_IDX_W;

endpackage

// File: rtl/dc_wb_buffer.sv
// Single-entry writeback line buffer: captures a dirty line, forwards words to matching reads,
// and presents the next word to drain along with its memory address.
module dc_wb_buffer
  import dc_mem_bridge_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = DC_LINE_WORDS,
  parameter int IDX_W      = $clog2(LINE_WORDS),
  parameter int TAG_W      = ADDR_W - DC_WORD_LSB - IDX_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            capture,
  input  logic [TAG_W-1:0]                capture_line,
  input  logic [LINE_WORDS*DC_WORD_W-1:0] capture_data,
  input  logic                            advance,
  input  logic [TAG_W-1:0]                lookup_line,
  input  logic [IDX_W-1:0]                lookup_word,
  output logic                            valid,
  output logic                            hit,
  output logic [DC_WORD_W-1:0]            hit_word,
  output logic [ADDR_W-1:0]               drain_addr,
  output logic [DC_WORD_W-1:0]            drain_word
);

  logic                 valid_q;
  logic [TAG_W-1:0]     line_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DC_WORD_W-1:0] data_q [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      line_q  <= '0;
      for (int k = 0; k < LINE_WORDS; k++) data_q[k] <= '0;
    end else if (capture) begin
      valid_q <= 1'b1;
      idx_q   <= '0;
      line_q  <= capture_line;
      for (int k = 0; k < LINE_WORDS; k++) data_q[k] <= capture_data[k*DC_WORD_W +: DC_WORD_W];
    end else if (advance) begin
      // The last word retires the entry; the index wraps so the next capture starts clean.
      if (idx_q == IDX_W'(LINE_WORDS - 1)) begin
        valid_q <= 1'b0;
        idx_q   <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign valid      = valid_q;
  assign hit        = valid_q && (lookup_line == line_q);
  assign hit_word   = data_q[lookup_word];
  assign drain_word = data_q[idx_q];
  assign drain_addr = {line_q, idx_q, {DC_WORD_LSB{1'b0}}};

endmodule

// File: rtl/dc_mem_bridge.sv
// Data-cache to memory bridge: serves word reads (forwarded from the writeback buffer when it holds
// the line, otherwise from memory) and drains the buffered dirty line one word at a time.
//
//   state  | meaning
//   IDLE   | arbitrate: new read first, then drain one buffered word, then accept a writeback
//   RD_MEM | memory read in flight, waiting for mem_ready
//   WR_MEM | one writeback word in flight, waiting for mem_ready
module dc_mem_bridge
  import dc_mem_bridge_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = DC_LINE_WORDS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            is_request,
  input  logic [ADDR_W-1:0]               request_addr,
  output logic [DC_WORD_W-1:0]            requested_data,
  output logic                            rd_valid,
  input  logic                            is_wb,
  input  logic [LINE_WORDS*DC_WORD_W-1:0] wb_data,
  output logic                            wb_ack,
  output logic                            mem_req,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DC_WORD_W-1:0]            mem_wdata,
  input  logic [DC_WORD_W-1:0]            mem_rdata,
  input  logic                            mem_ready
);

  localparam int IDX_W    = $clog2(LINE_WORDS);
  localparam int LINE_LSB = DC_WORD_LSB + IDX_W;
  localparam int TAG_W    = ADDR_W - LINE_LSB;

  bridge_state_t        state, state_nxt;
  logic [ADDR_W-1:0]    rd_addr_q;
  logic                 req_new;
  logic                 hit_take, miss_take, rd_done;
  logic                 capture, advance;
  logic                 buf_valid, buf_hit;
  logic [DC_WORD_W-1:0] hit_word, drain_word;
  logic [ADDR_W-1:0]    drain_addr;

  // Byte-offset bits of the request address carry no information for word accesses.
  logic unused_byte_offset;
  assign unused_byte_offset = ^request_addr[DC_WORD_LSB-1:0];

  dc_wb_buffer #(
    .ADDR_W     (ADDR_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_wb_buffer (
    .clk          (clk),
    .reset        (reset),
    .capture      (capture),
    .capture_line (request_addr[ADDR_W-1:LINE_LSB]),
    .capture_data (wb_data),
    .advance      (advance),
    .lookup_line  (request_addr[ADDR_W-1:LINE_LSB]),
    .lookup_word  (request_addr[LINE_LSB-1:DC_WORD_LSB]),
    .valid        (buf_valid),
    .hit          (buf_hit),
    .hit_word     (hit_word),
    .drain_addr   (drain_addr),
    .drain_word   (drain_word)
  );

  // The requester holds is_request through its rd_valid cycle; that cycle is not a new read.
  assign req_new = is_request && !rd_valid;

  always_comb begin
    state_nxt = state;
    hit_take  = 1'b0;
    miss_take = 1'b0;
    rd_done   = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    case (state)
      IDLE: begin
        if (req_new) begin
          if (buf_hit) begin
            hit_take = 1'b1;
          end else begin
            miss_take = 1'b1;
            state_nxt = RD_MEM;
          end
        end else if (buf_valid) begin
          state_nxt = WR_MEM;
        end else if (is_wb) begin
          capture = 1'b1;
        end
      end
      RD_MEM: begin
        if (mem_ready) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_MEM: begin
        if (mem_ready) begin
          advance   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      RD_MEM: begin
        mem_req  = 1'b1;
        mem_addr = rd_addr_q;
      end
      WR_MEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = drain_addr;
        mem_wdata = drain_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      rd_addr_q      <= '0;
      requested_data <= '0;
      rd_valid       <= 1'b0;
      wb_ack         <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= hit_take || rd_done;
      wb_ack   <= capture;
      if (miss_take) rd_addr_q <= {request_addr[ADDR_W-1:DC_WORD_LSB], {DC_WORD_LSB{1'b0}}};
      if (hit_take)     requested_data <= hit_word;
      else if (rd_done) requested_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dc_mem_bridge.sv
// Directed bench for dc_mem_bridge: miss read, writeback drain, forwarding, preemption,
// writeback back-pressure and reset during a memory read.
module tb_dc_mem_bridge;

  logic         clk;
  logic         reset;
  logic         is_request;
  logic [31:0]  request_addr;
  logic [31:0]  requested_data;
  logic         rd_valid;
  logic         is_wb;
  logic [255:0] wb_data;
  logic         wb_ack;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [63:0] wr_log [$];
  int wb_ack_cnt = 0;
  int rd_valid_cnt = 0;
  int both_cnt = 0;
  int mem_rd_cnt = 0;

  dc_mem_bridge #(.ADDR_W(32), .LINE_WORDS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .is_request     (is_request),
    .request_addr   (request_addr),
    .requested_data (requested_data),
    .rd_valid       (rd_valid),
    .is_wb          (is_wb),
    .wb_data        (wb_data),
    .wb_ack         (wb_ack),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs only change 1 time unit after a rising edge, so what is seen at the falling
  // edge is exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (mem_req && mem_ready && mem_we) wr_log.push_back({mem_addr, mem_wdata});
    if (mem_req && mem_ready && !mem_we) mem_rd_cnt++;
    if (wb_ack) wb_ack_cnt++;
    if (rd_valid) rd_valid_cnt++;
    if (wb_ack && rd_valid) both_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input logic [31:0] base);
    for (int k = 0; k < 8; k++) wb_data[32*k +: 32] = base + 32'(k);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_req"},  64'(mem_req), 64'd0);
    check({tag, "_mem_we"},   64'(mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    check({tag, "_wb_ack"},   64'(wb_ack), 64'd0);
    check({tag, "_rdata"},    64'(requested_data), 64'd0);
  endtask

  task automatic check_line(input string tag, input int first, input logic [31:0] addr0,
                            input logic [31:0] data0);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_w%0d", tag, k), wr_log[first + k],
            {addr0 + 32'(4 * k), data0 + 32'(k)});
  endtask

  initial begin
    int guard;
    int ack0;
    int rd0;

    reset        = 1'b1;
    is_request   = 1'b0;
    request_addr = '0;
    is_wb        = 1'b0;
    wb_data      = '0;
    mem_rdata    = '0;
    mem_ready    = 1'b0;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Miss read with memory answering on the third request cycle
    is_request   = 1'b1;
    request_addr = 32'h0000_1004;
    step();
    check("miss_req",  64'(mem_req), 64'd1);
    check("miss_we",   64'(mem_we), 64'd0);
    check("miss_addr", 64'(mem_addr), 64'h1004);
    step();
    step();
    check("miss_addr_held", 64'(mem_addr), 64'h1004);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    check("miss_no_early_valid", 64'(rd_valid), 64'd0);
    step();
    check("miss_valid", 64'(rd_valid), 64'd1);
    check("miss_data",  64'(requested_data), 64'hDEAD_BEEF);
    check("miss_req_done", 64'(mem_req), 64'd0);
    is_request = 1'b0;
    mem_ready  = 1'b0;
    step();
    check("miss_valid_pulse", 64'(rd_valid), 64'd0);

    // Writeback of line 0x2000 plus a forwarded read from it before draining starts
    ack0 = wb_ack_cnt;
    rd0  = mem_rd_cnt;
    wr_log.delete();
    mem_ready    = 1'b1;
    request_addr = 32'h0000_2000;
    set_line(32'h10);
    is_wb = 1'b1;
    step();
    check("wb_ack", 64'(wb_ack), 64'd1);
    is_wb        = 1'b0;
    is_request   = 1'b1;
    request_addr = 32'h0000_2008;
    check("fwd_no_mem_a", 64'(mem_req), 64'd0);
    step();
    check("fwd_valid", 64'(rd_valid), 64'd1);
    check("fwd_data",  64'(requested_data), 64'h12);
    check("fwd_no_mem_b", 64'(mem_req), 64'd0);
    is_request = 1'b0;
    repeat (24) step();
    check("wb_count", 64'(wr_log.size()), 64'd8);
    check_line("wb", 0, 32'h0000_2000, 32'h10);
    check("wb_ack_once", 64'(wb_ack_cnt - ack0), 64'd1);
    check("fwd_no_mem_read", 64'(mem_rd_cnt - rd0), 64'd0);
    check("wb_idle_after", 64'(mem_req), 64'd0);

    // Preempt the drain of line 0x4000 with a miss read after word 3 is written
    wr_log.delete();
    request_addr = 32'h0000_4000;
    set_line(32'h20);
    is_wb = 1'b1;
    step();
    is_wb = 1'b0;
    guard = 0;
    while (wr_log.size() < 4 && guard < 40) begin
      step();
      guard++;
    end
    check("pre_reach_word4", 64'(guard < 40), 64'd1);
    check("pre_idle_gap", 64'(mem_req), 64'd0);
    is_request   = 1'b1;
    request_addr = 32'h0000_3000;
    mem_rdata    = 32'hCAFE_0003;
    step();
    check("pre_rd_req",  64'(mem_req), 64'd1);
    check("pre_rd_we",   64'(mem_we), 64'd0);
    check("pre_rd_addr", 64'(mem_addr), 64'h3000);
    step();
    check("pre_rd_valid", 64'(rd_valid), 64'd1);
    check("pre_rd_data",  64'(requested_data), 64'hCAFE_0003);
    check("pre_paused",   64'(wr_log.size()), 64'd4);
    is_request = 1'b0;
    repeat (24) step();
    check("pre_count", 64'(wr_log.size()), 64'd8);
    check_line("pre", 0, 32'h0000_4000, 32'h20);

    // Second writeback offered while the first line is still draining
    wr_log.delete();
    ack0 = wb_ack_cnt;
    request_addr = 32'h0000_5000;
    set_line(32'h30);
    is_wb = 1'b1;
    step();
    check("bp_first_ack", 64'(wb_ack), 64'd1);
    request_addr = 32'h0000_6000;
    set_line(32'h40);
    guard = 0;
    do begin
      step();
      guard++;
    end while (!wb_ack && guard < 60);
    check("bp_second_ack_seen", 64'(guard < 60), 64'd1);
    check("bp_ack_after_drain", 64'(wr_log.size()), 64'd8);
    is_wb = 1'b0;
    repeat (24) step();
    check("bp_count", 64'(wr_log.size()), 64'd16);
    check("bp_ack_total", 64'(wb_ack_cnt - ack0), 64'd2);
    check_line("bp_l1", 0, 32'h0000_5000, 32'h30);
    check_line("bp_l2", 8, 32'h0000_6000, 32'h40);

    // Reset while a memory read is outstanding, with mem_ready arriving in the reset cycle
    mem_ready    = 1'b0;
    is_request   = 1'b1;
    request_addr = 32'h0000_7000;
    step();
    check("rst_in_rd", 64'(mem_req), 64'd1);
    reset     = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    step();
    check_all_zero("rst_mid");
    reset      = 1'b0;
    is_request = 1'b0;
    mem_ready  = 1'b0;
    step();
    check("rst_no_retry_req",   64'(mem_req), 64'd0);
    check("rst_no_retry_valid", 64'(rd_valid), 64'd0);
    is_request   = 1'b1;
    request_addr = 32'h0000_700B;
    mem_ready    = 1'b1;
    mem_rdata    = 32'h1357_2468;
    step();
    check("post_rst_req",  64'(mem_req), 64'd1);
    check("post_rst_addr", 64'(mem_addr), 64'h7008);
    step();
    check("post_rst_valid", 64'(rd_valid), 64'd1);
    check("post_rst_data",  64'(requested_data), 64'h1357_2468);
    is_request = 1'b0;
    mem_ready  = 1'b0;
    step();

    check("never_both_pulses", 64'(both_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
